inst_fetch_unit: RTL
====================

# inst_fetch_unit

Instruction fetch stage for the lab RISC-V core: holds the PC, issues one-at-a-time requests to instruction memory, and presents each fetched instruction word with its PC to decode/immediate generation under a valid/ready handshake. Accepts taken-branch redirects carrying the branch PC and the raw B-type immediate (bit 0 omitted) produced downstream, computes the target, and squashes stale fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  one-cycle request pulse to instruction memory
- imem_addr  out  32  word-aligned fetch address; valid while imem_req=1
- imem_rvalid  in  1  response strobe, ≥1 cycle after imem_req; exactly one per request
- imem_rdata  in  32  instruction word; valid with imem_rvalid
- inst_out  out  32  held instruction to decode
- pc_out  out  32  PC of inst_out
- inst_valid  out  1  inst_out/pc_out valid; = hold state AND NOT br_taken
- inst_ready  in  1  decode accepts when inst_valid & inst_ready
- br_taken  in  1  redirect request, single-cycle
- br_pc  in  32  PC of the resolved branch
- br_imm  in  32  sign-extended B-type offset in halfword units (bit 0 omitted)

## Operation
- State: pc_q (32), inst_q, pcout_q, squash_q, FSM {IDLE, REQ, WAIT, HOLD}.
- Target = br_pc + (br_imm << 1), modulo 2^32; bits [1:0] forced to 2'b00.
- Sequential PC increment: pc_q + 4, wraps 32'hFFFF_FFFC → 32'h0000_0000.
- IDLE: entered only by reset; next cycle → REQ.
- REQ: imem_req=1, imem_addr=pc_q (Moore, one cycle); → WAIT.
- WAIT: on imem_rvalid with squash_q=0 and br_taken=0: inst_q←imem_rdata, pcout_q←pc_q, pc_q←pc_q+4, → HOLD. On imem_rvalid with squash_q=1: discard data, clear squash_q, → REQ.
- HOLD: inst_valid=1 (unless br_taken). On inst_valid & inst_ready → REQ. Otherwise hold inst_out/pc_out stable.
- Redirect (br_taken=1), priority over every other event:
  - IDLE: pc_q←target; → REQ.
  - REQ: pc_q←target; squash_q←1 (outstanding request is stale); → WAIT.
  - WAIT, no rvalid this cycle: pc_q←target; squash_q←1; stay WAIT.
  - WAIT with rvalid this cycle: data discarded; pc_q←target; squash_q←0; → REQ.
  - HOLD: inst_valid forced 0 combinationally (no transfer even if inst_ready=1); pc_q←target; → REQ.
- Back-to-back redirects: latest target wins; squash_q stays set until the single outstanding response returns.
- Memory protocol violations (rvalid outside WAIT) are ignored.

## Timing
- Reset (async assert, sync-to-clk release by flop behaviour): pc_q=RESET_PC, FSM=IDLE, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, pc_out=0, squash_q=0. Reset mid-request abandons it; a late rvalid after reset release lands in IDLE/REQ and is ignored.
- First imem_req: second rising edge after rst_n deasserts (IDLE one cycle, then REQ).
- Request at cycle t, rvalid at t+k (k≥1) → inst_valid at t+k+1.
- Handshake at cycle h → next imem_req at h+1.
- Steady-state with k=1 and inst_ready=1: one instruction per 3 cycles.
- inst_valid depends combinationally on br_taken only; all other outputs registered.

## Test plan
- Reset with RESET_PC=0x100, memory latency k=1, inst_ready=1 → requests to 0x100, 0x104, 0x108 at cycles 1, 4, 7 after release; inst_valid one cycle after each rvalid with matching pc_out.
- Latency k=3, inst_ready held 0 for 5 cycles in HOLD → inst_out/pc_out stable, no imem_req until ready; then request to pc_out+4.
- br_taken in WAIT with br_pc=0x200, br_imm=0xFFFF_FFF8 → target 0x1F0; returning stale word never appears on inst_valid; next request addr 0x1F0.
- br_taken in HOLD same cycle as inst_ready=1 → inst_valid=0 that cycle, no transfer; next request to target.
- br_taken coinciding with rvalid in WAIT → data dropped, REQ next cycle to target, squash_q=0.
- RESET_PC=0xFFFF_FFFC → second request address 0x0000_0000; rst_n pulsed low mid-WAIT → outputs return to reset values immediately, late rvalid ignored.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handshake
// and taken-branch redirect.
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic        inst_ready;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [31:0] br_imm;

  modport master (
    output imem_req, imem_addr, inst_out, pc_out, inst_valid,
    input  imem_rvalid, imem_rdata, inst_ready, br_taken, br_pc, br_imm
  );

  modport slave (
    input  imem_req, imem_addr, inst_out, pc_out, inst_valid,
    output imem_rvalid, imem_rdata, inst_ready, br_taken, br_pc, br_imm
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request at a time, holds the
// fetched word for decode, and redirects on taken branches with stale-fetch squash.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst_n,
  inst_fetch_unit_if.master bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pcout_q, pcout_d;
  logic        squash_q, squash_d;
  logic [31:0] target_sum;
  logic [31:0] target;

  // br_imm counts halfwords; low two bits of the target are forced to zero.
  assign target_sum = bus.br_pc + (bus.br_imm << 1);
  assign target     = target_sum & 32'hFFFF_FFFC;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pcout_d  = pcout_q;
    squash_d = squash_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (bus.br_taken) pc_d = target;
      end
      REQ: begin
        state_d = WAIT;
        if (bus.br_taken) begin
          pc_d     = target;
          squash_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.br_taken) begin
          pc_d = target;
          if (bus.imem_rvalid) begin
            // The response arriving now is the one we were waiting on; drop it.
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = REQ;
          end else begin
            inst_d  = bus.imem_rdata;
            pcout_d = pc_q;
            pc_d    = pc_q + 32'd4;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.br_taken) begin
          pc_d    = target;
          state_d = REQ;
        end else if (bus.inst_ready) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      inst_q   <= 32'h0;
      pcout_q  <= 32'h0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pcout_q  <= pcout_d;
      squash_q <= squash_d;
    end
  end

  assign bus.imem_req   = (state_q == REQ);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_out   = inst_q;
  assign bus.pc_out     = pcout_q;
  // A redirect in HOLD must block the transfer in the same cycle.
  assign bus.inst_valid = (state_q == HOLD) & ~bus.br_taken;

endmodule
